mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory stage directly downstream of EX. It accepts EX results (we/waddr/wdata) plus a memory-op descriptor, and performs loads and stores over the byte-wide single-port RAM port with a byte-serial FSM. It delivers the final register write (we/waddr/wdata) to MEM/WB and raises stall_req to the pipeline controller while a multi-cycle access is in flight. Non-memory ops pass through with 1-cycle latency.

Parameters:
ADDR_W, 17, width of RAM byte address driven on mem_a (effective address truncated).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rdy  in  1  global ready; low freezes all state
in_valid  in  1  EX presents an op this cycle
in_ready  out  1  stage can accept; equals (state==IDLE)
ex_we  in  1  register write enable from EX
ex_waddr  in  5  destination register
ex_wdata  in  32  ALU result; effective address for memory ops
ex_sdata  in  32  store data (rs2)
ex_memop  in  5  [4]=mem op, [3]=store, [2]=unsigned load, [1:0]=size (00 B, 01 H, 10 W, 11 reserved->treated as W)
mem_a  out  ADDR_W  RAM byte address
mem_dout  out  8  RAM write byte
mem_wr  out  1  RAM write strobe
mem_din  in  8  RAM read byte; valid the cycle after its address is driven
wb_valid  out  1  one-cycle pulse: wb_* hold a completed op
wb_we  out  1  register write enable to MEM/WB
wb_waddr  out  5  destination register
wb_wdata  out  32  register write data
stall_req  out  1  equals ~in_ready; to pipeline controller

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, byte counter=0, all wb_* = 0, mem_a=0, mem_dout=0, mem_wr=0. Reset mid-access aborts it; no further RAM writes are issued.
- rdy=0: every register holds its value, mem_wr forced 0, and in_valid is ignored. Resumes exactly where it stopped.
- States: IDLE, XFER, LAST (load only).
- IDLE and in_valid:
  - Non-memory op (memop[4]=0): at the accepting edge, wb_valid=1, wb_we=ex_we, wb_waddr=ex_waddr, wb_wdata=ex_wdata. State stays IDLE.
  - Memory op: latch addr, sdata, op, waddr, and we; cnt=0; N=1/2/4 from size; next state XFER; wb_valid=0.
- XFER (cycle index cnt):
  - mem_a = (addr+cnt)[ADDR_W-1:0], with 32-bit wrap before truncation.
  - Store: mem_wr=1, mem_dout=sdata[8cnt+7:8cnt] (little-endian).
  - Load: mem_wr=0.
  - At each edge, cnt++. Load bytes arriving on mem_din are packed into byte lane cnt-1.
  - When cnt==N-1 at the edge:
    - Store goes to IDLE and pulses wb_valid with wb_we=0, wb_waddr=0, wb_wdata=0.
    - Load goes to LAST.
- LAST: mem_wr=0. At the edge, the final byte is packed and the result is sign- or zero-extended from 8/16 bits per memop[2]. wb_valid=1, wb_we=latched we, wb_waddr=latched waddr. State goes to IDLE.
- Latency from the accepting edge E to the wb_valid pulse (in cycles after edges):
  - Non-memory: E.
  - Store: E+N.
  - Load: E+N+1.
- in_ready returns high in the same cycle wb_valid is high, so back-to-back ops are allowed. wb_valid is 0 in all other cycles, and wb_* hold their last values.
- mem_wr is asserted only in XFER for a store. It is never asserted in IDLE or LAST.
- Misaligned addresses are legal; no trap.
- Load with waddr=0 is still performed; wb_we passes through unchanged and x0 suppression is the register file's job.

Decomposition:
- defines.v gains:
  - MemOpBus [4:0].
  - Field indices MEMOP_VALID, MEMOP_STORE, MEMOP_UNS.
  - Size codes SZ_B, SZ_H, SZ_W.
  - State codes MEM_IDLE, MEM_XFER, MEM_LAST.
- Reuse RegBus, RegAddrBus, RstEnable, True_v, False_v, and ZeroWord from defines.v.
- One sub-module, mem_extend: a combinational size/sign extension of the packed load word.

Test Plan:
- ADD result in_valid=1, ex_we=1, waddr=5, wdata=0x1234 -> wb_valid next cycle, wb_waddr=5, wb_wdata=0x1234, in_ready stays 1, mem_wr never 1.
- SW addr=0x100, sdata=0xA1B2C3D4 -> 4 cycles of mem_wr=1 with (mem_a, mem_dout) = (0x100,D4), (0x101,C3), (0x102,B2), (0x103,A1); wb_valid with wb_we=0 in the next cycle; stall_req high for exactly 4 cycles.
- RAM preloaded with 0x80,0xFF at 0x200: LH -> wb_wdata=0xFFFFFF80; LHU -> 0x0000FF80; LB at 0x201 -> 0xFFFFFFFF; each load pulses wb_valid N+1 cycles after acceptance.
- LW at 0x1FFFF with ADDR_W=17 -> mem_a sequence 0x1FFFF, 0x00000, 0x00001, 0x00002; data packed little-endian.
- SW in progress with rdy=0 held 3 cycles after the 2nd byte -> no mem_wr while rdy=0, mem_a frozen, remaining 2 bytes are written after rdy returns, total writes=4.
- rst=1 during the 3rd byte of SW -> next cycle state=IDLE, mem_wr=0, in_ready=1, wb_*=0; bytes 3–4 are never written.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: op-descriptor fields, size codes,
// FSM state codes and the latched request record.
package mem_stage_pkg;

  localparam int REG_W   = 32;
  localparam int REG_AW  = 5;
  localparam int MEMOP_W = 5;

  localparam int MEMOP_VALID = 4;
  localparam int MEMOP_STORE = 3;
  localparam int MEMOP_UNS   = 2;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_XFER = 2'd1;
  localparam logic [1:0] MEM_LAST = 2'd2;

  localparam logic [REG_W-1:0] ZERO_WORD = '0;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [REG_W-1:0]  sdata;
    logic              store;
    logic              uns;
    logic [1:0]        size;
    logic [REG_AW-1:0] waddr;
    logic              we;
  } mem_req_t;

  // Index of the final byte of an access; the reserved size code acts as a word.
  function automatic logic [2:0] last_idx(input logic [1:0] size);
    logic [2:0] idx;
    case (size)
      SZ_B:    idx = 3'd0;
      SZ_H:    idx = 3'd1;
      default: idx = 3'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_extend.sv
// Size and sign/zero extension of a little-endian packed load word.
module mem_extend
  import mem_stage_pkg::*;
(
  input  logic [REG_W-1:0] word,
  input  logic [1:0]       size,
  input  logic             uns,
  output logic [REG_W-1:0] result
);

  always_comb begin
    result = word;
    case (size)
      SZ_B:    result = {{24{~uns & word[7]}}, word[7:0]};
      SZ_H:    result = {{16{~uns & word[15]}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through in one cycle and performs byte-serial
// loads/stores over a byte-wide single-port RAM, stalling the pipeline meanwhile.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic [REG_W-1:0]  ex_wdata,
  input  logic [REG_W-1:0]  ex_sdata,
  input  logic [MEMOP_W-1:0] ex_memop,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [REG_W-1:0]  wb_wdata,
  output logic              stall_req
);

  // Handshake: an op transfers on a rising edge where in_valid & in_ready & rdy;
  // in_ready is high only in IDLE and does not depend on in_valid.
  logic [1:0]       state;
  logic [2:0]       cnt;
  mem_req_t         req;
  logic [REG_W-1:0] acc;
  logic [REG_W-1:0] acc_next;
  logic [REG_W-1:0] load_word;
  logic [REG_W-1:0] eff_addr;
  logic [1:0]       lane;
  logic             last_beat;

  assign in_ready  = (state == MEM_IDLE);
  assign stall_req = ~in_ready;
  assign eff_addr  = req.addr + {29'd0, cnt};
  assign last_beat = (cnt == last_idx(req.size));
  // RAM data lags its address by one cycle, so the arriving byte belongs to lane cnt-1.
  assign lane      = cnt[1:0] - 2'd1;

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (state == MEM_XFER) begin
      mem_a = eff_addr[ADDR_W-1:0];
      if (req.store) begin
        mem_dout = req.sdata[{cnt[1:0], 3'b000} +: 8];
        mem_wr   = rdy & ~rst;
      end
    end
  end

  always_comb begin
    acc_next = acc;
    acc_next[{lane, 3'b000} +: 8] = mem_din;
  end

  mem_extend u_extend (
    .word   (acc_next),
    .size   (req.size),
    .uns    (req.uns),
    .result (load_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MEM_IDLE;
      cnt      <= '0;
      req      <= '0;
      acc      <= '0;
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= ZERO_WORD;
    end else if (rdy) begin
      wb_valid <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (in_valid) begin
            if (!ex_memop[MEMOP_VALID]) begin
              wb_valid <= 1'b1;
              wb_we    <= ex_we;
              wb_waddr <= ex_waddr;
              wb_wdata <= ex_wdata;
            end else begin
              req   <= '{addr: ex_wdata, sdata: ex_sdata, store: ex_memop[MEMOP_STORE],
                         uns: ex_memop[MEMOP_UNS], size: ex_memop[1:0],
                         waddr: ex_waddr, we: ex_we};
              cnt   <= '0;
              acc   <= '0;
              state <= MEM_XFER;
            end
          end
        end
        MEM_XFER: begin
          cnt <= cnt + 3'd1;
          if (cnt != 3'd0) acc <= acc_next;
          if (last_beat) begin
            if (req.store) begin
              state    <= MEM_IDLE;
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_waddr <= '0;
              wb_wdata <= ZERO_WORD;
            end else begin
              state <= MEM_LAST;
            end
          end
        end
        MEM_LAST: begin
          state    <= MEM_IDLE;
          wb_valid <= 1'b1;
          wb_we    <= req.we;
          wb_waddr <= req.waddr;
          wb_wdata <= load_word;
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized ops against a
// byte-addressed reference memory and expected RAM-write queue.
module tb_mem_stage;

  localparam int ADDR_W = 17;
  localparam int WR_W   = ADDR_W + 8;
  localparam logic [31:0] A_MASK = (32'd1 << ADDR_W) - 32'd1;

  logic              clk = 1'b0;
  logic              rst, rdy, in_valid, in_ready;
  logic              ex_we;
  logic [4:0]        ex_waddr;
  logic [31:0]       ex_wdata, ex_sdata;
  logic [4:0]        ex_memop;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0]        mem_dout, mem_din;
  logic              mem_wr;
  logic              wb_valid, wb_we;
  logic [4:0]        wb_waddr;
  logic [31:0]       wb_wdata;
  logic              stall_req;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_ready(in_ready),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_sdata(ex_sdata),
    .ex_memop(ex_memop), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .mem_din(mem_din), .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .stall_req(stall_req)
  );

  // Synchronous byte RAM, frozen along with the pipeline when rdy is low.
  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic              poke_en = 1'b0;
  logic [ADDR_W-1:0] poke_addr;
  logic [7:0]        poke_data;

  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (rdy) begin
      if (mem_wr) ram[mem_a] <= mem_dout;
      mem_din <= ram[mem_a];
    end
  end

  logic [7:0]        ref_mem [int];
  logic [WR_W-1:0]   exp_q [$];
  logic [WR_W-1:0]   wr_q [$];
  logic [ADDR_W-1:0] obs_a [$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int ref_n(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns);
    int n = ref_n(size);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v | ({24'd0, ref_rd(int'((addr + 32'(i)) & A_MASK))} << (8 * i));
    if (n == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic poke(input int a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a[ADDR_W-1:0]; poke_data = d; ref_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Presents one op (caller is at a negedge with the stage idle) and waits for wb_valid.
  task automatic do_op(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                       input logic [31:0] sdata, input logic [4:0] memop,
                       output int lat, output int stalls);
    in_valid = 1'b1; ex_we = we; ex_waddr = waddr; ex_wdata = wdata;
    ex_sdata = sdata; ex_memop = memop;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0; stalls = 0;
    obs_a.delete(); wr_q.delete();
    while (wb_valid !== 1'b1 && lat < 12) begin
      if (stall_req) stalls++;
      obs_a.push_back(mem_a);
      if (mem_wr) wr_q.push_back({mem_a, mem_dout});
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; ex_we = 1'b0; ex_waddr = '0;
    ex_wdata = '0; ex_sdata = '0; ex_memop = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", stall_req); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0h exp=0", wb_valid); end
    checks++; if ({wb_we, wb_waddr, wb_wdata} !== 38'd0) begin failures++; $display("FAIL reset_wb got=%0h exp=0", {wb_we, wb_waddr, wb_wdata}); end
    checks++; if ({mem_wr, mem_a, mem_dout} !== 26'd0) begin failures++; $display("FAIL reset_mem_port got=%0h exp=0", {mem_wr, mem_a, mem_dout}); end
  endtask

  task automatic test_alu();
    int lat, st;
    do_op(1'b1, 5'd5, 32'h1234, 32'h0, 5'b00000, lat, st);
    checks++; if (lat !== 0) begin failures++; $display("FAIL alu_latency got=%0d exp=0", lat); end
    checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'd5) begin failures++; $display("FAIL alu_dest got=%0h/%0d exp=1/5", wb_we, wb_waddr); end
    checks++; if (wb_wdata !== 32'h1234) begin failures++; $display("FAIL alu_wdata got=%0h exp=1234", wb_wdata); end
    checks++; if (in_ready !== 1'b1 || mem_wr !== 1'b0 || st !== 0) begin failures++; $display("FAIL alu_no_stall got=%0h/%0h/%0d exp=1/0/0", in_ready, mem_wr, st); end
  endtask

  task automatic test_store_word();
    int lat, st;
    logic [31:0] sd = 32'hA1B2_C3D4;
    logic [31:0] sh;
    do_op(1'b0, 5'd7, 32'h100, sd, 5'b11010, lat, st);
    checks++; if (lat !== 4 || st !== 4) begin failures++; $display("FAIL sw_latency got=%0d/%0d exp=4/4", lat, st); end
    checks++; if ({wb_we, wb_waddr, wb_wdata} !== 38'd0) begin failures++; $display("FAIL sw_wb got=%0h exp=0", {wb_we, wb_waddr, wb_wdata}); end
    checks++; if (wr_q.size() !== 4) begin failures++; $display("FAIL sw_write_count got=%0d exp=4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      sh = sd >> (8 * i);
      ref_mem[32'h100 + i] = sh[7:0];
      checks++;
      if (wr_q[i] !== {17'(32'h100 + i), sh[7:0]}) begin
        failures++; $display("FAIL sw_byte%0d got=%0h exp=%0h", i, wr_q[i], {17'(32'h100 + i), sh[7:0]});
      end
    end
  endtask

  task automatic test_loads();
    logic [31:0] la [4] = '{32'h200, 32'h200, 32'h201, 32'h201};
    logic [4:0]  lo [4] = '{5'b10001, 5'b10101, 5'b10000, 5'b10100};
    logic [31:0] lv [4] = '{32'hFFFF_FF80, 32'h0000_FF80, 32'hFFFF_FFFF, 32'h0000_00FF};
    int          ll [4] = '{3, 3, 2, 2};
    int lat, st;
    poke(32'h200, 8'h80);
    poke(32'h201, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 5'(i + 1), la[i], 32'h0, lo[i], lat, st);
      checks++; if (lat !== ll[i]) begin failures++; $display("FAIL load%0d_latency got=%0d exp=%0d", i, lat, ll[i]); end
      checks++; if (wb_wdata !== lv[i]) begin failures++; $display("FAIL load%0d_wdata got=%0h exp=%0h", i, wb_wdata, lv[i]); end
      checks++; if (wb_we !== 1'b1 || wb_waddr !== 5'(i + 1) || wr_q.size() !== 0) begin
        failures++; $display("FAIL load%0d_dest got=%0h/%0d/%0d exp=1/%0d/0", i, wb_we, wb_waddr, wr_q.size(), i + 1);
      end
    end
  endtask

  task automatic test_wrap();
    int lat, st;
    logic [ADDR_W-1:0] ea [4] = '{17'h1FFFF, 17'h00000, 17'h00001, 17'h00002};
    poke(32'h1FFFF, 8'h11); poke(32'h0, 8'h22); poke(32'h1, 8'h33); poke(32'h2, 8'h44);
    do_op(1'b1, 5'd9, 32'h0001_FFFF, 32'h0, 5'b10010, lat, st);
    checks++; if (lat !== 5) begin failures++; $display("FAIL wrap_latency got=%0d exp=5", lat); end
    checks++; if (wb_wdata !== 32'h4433_2211) begin failures++; $display("FAIL wrap_wdata got=%0h exp=44332211", wb_wdata); end
    for (int i = 0; i < 4 && i < obs_a.size(); i++) begin
      checks++; if (obs_a[i] !== ea[i]) begin failures++; $display("FAIL wrap_addr%0d got=%0h exp=%0h", i, obs_a[i], ea[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, st;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, 5'(10 + i), 32'hC0DE_0000 + 32'(i), 32'h0, 5'b01111, lat, st);
      checks++; if (lat !== 0 || wb_wdata !== 32'hC0DE_0000 + 32'(i) || wb_waddr !== 5'(10 + i)) begin
        failures++; $display("FAIL b2b%0d got=%0d/%0h/%0d exp=0/%0h/%0d", i, lat, wb_wdata, wb_waddr, 32'hC0DE_0000 + 32'(i), 10 + i);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] sd = 32'h5566_7788;
    logic [31:0] sh;
    int guard = 0;
    in_valid = 1'b1; ex_we = 1'b0; ex_waddr = '0; ex_wdata = 32'h400; ex_sdata = sd; ex_memop = 5'b11010;
    @(negedge clk);
    in_valid = 1'b0;
    wr_q.delete();
    repeat (2) begin
      if (mem_wr) wr_q.push_back({mem_a, mem_dout});
      @(negedge clk);
    end
    rdy = 1'b0; in_valid = 1'b1; ex_memop = 5'b00000;
    #1;
    repeat (3) begin
      checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL stall_mem_wr got=%0h exp=0", mem_wr); end
      checks++; if (mem_a !== 17'h402 || stall_req !== 1'b1 || wb_valid !== 1'b0) begin
        failures++; $display("FAIL stall_frozen got=%0h/%0h/%0h exp=402/1/0", mem_a, stall_req, wb_valid);
      end
      @(negedge clk);
    end
    rdy = 1'b1; in_valid = 1'b0;
    #1;
    while (wb_valid !== 1'b1 && guard < 10) begin
      if (mem_wr) wr_q.push_back({mem_a, mem_dout});
      @(negedge clk);
      guard++;
    end
    checks++; if (wb_valid !== 1'b1 || guard !== 2) begin failures++; $display("FAIL stall_resume got=%0h/%0d exp=1/2", wb_valid, guard); end
    checks++; if (wr_q.size() !== 4) begin failures++; $display("FAIL stall_write_count got=%0d exp=4", wr_q.size()); end
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      sh = sd >> (8 * i);
      ref_mem[32'h400 + i] = sh[7:0];
      checks++;
      if (wr_q[i] !== {17'(32'h400 + i), sh[7:0]}) begin
        failures++; $display("FAIL stall_byte%0d got=%0h exp=%0h", i, wr_q[i], {17'(32'h400 + i), sh[7:0]});
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, st;
    int late_wr = 0;
    poke(32'h502, 8'h5A);
    poke(32'h503, 8'hA5);
    do_op(1'b1, 5'd12, 32'hDEAD_BEEF, 32'h0, 5'b00000, lat, st);
    in_valid = 1'b1; ex_we = 1'b0; ex_waddr = '0; ex_wdata = 32'h500; ex_sdata = 32'h1122_3344; ex_memop = 5'b11010;
    @(negedge clk);
    in_valid = 1'b0;
    wr_q.delete();
    repeat (2) begin
      if (mem_wr) wr_q.push_back({mem_a, mem_dout});
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL rstmid_byte3_wr got=%0h exp=0", mem_wr); end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || stall_req !== 1'b0 || mem_wr !== 1'b0) begin
      failures++; $display("FAIL rstmid_idle got=%0h/%0h/%0h exp=1/0/0", in_ready, stall_req, mem_wr);
    end
    checks++; if ({wb_valid, wb_we, wb_waddr, wb_wdata} !== 39'd0) begin
      failures++; $display("FAIL rstmid_wb got=%0h exp=0", {wb_valid, wb_we, wb_waddr, wb_wdata});
    end
    checks++; if (wr_q.size() !== 2) begin failures++; $display("FAIL rstmid_write_count got=%0d exp=2", wr_q.size()); end
    ref_mem[32'h500] = 8'h44;
    ref_mem[32'h501] = 8'h33;
    repeat (3) begin
      if (mem_wr) late_wr++;
      @(negedge clk);
    end
    checks++; if (late_wr !== 0) begin failures++; $display("FAIL rstmid_late_writes got=%0d exp=0", late_wr); end
    do_op(1'b1, 5'd3, 32'h502, 32'h0, 5'b10101, lat, st);
    checks++; if (wb_wdata !== 32'h0000_A55A || lat !== 3) begin failures++; $display("FAIL rstmid_untouched got=%0h/%0d exp=a55a/3", wb_wdata, lat); end
    do_op(1'b1, 5'd4, 32'h500, 32'h0, 5'b10101, lat, st);
    checks++; if (wb_wdata !== 32'h0000_3344) begin failures++; $display("FAIL rstmid_written got=%0h exp=3344", wb_wdata); end
  endtask

  task automatic test_random();
    int lat, st, kind, n, exp_lat;
    logic [1:0]  size;
    logic        uns, we;
    logic [4:0]  waddr;
    logic [31:0] addr, sdata, sh, exp_data;
    logic        exp_we;
    logic [4:0]  exp_waddr;
    logic [WR_W-1:0] got_w, exp_w;
    for (int a = 32'h300; a < 32'h340; a++) poke(a, 8'($urandom_range(0, 255)));
    for (int t = 0; t < 60; t++) begin
      kind  = $urandom_range(0, 2);
      size  = 2'($urandom_range(0, 3));
      uns   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 31));
      sdata = $urandom;
      addr  = (kind == 0) ? $urandom : 32'h300 + 32'($urandom_range(0, 60));
      n = ref_n(size);
      exp_q.delete();
      if (kind == 0) begin
        exp_lat = 0; exp_we = we; exp_waddr = waddr; exp_data = addr;
      end else if (kind == 1) begin
        exp_lat = n + 1; exp_we = we; exp_waddr = waddr; exp_data = ref_load(addr, size, uns);
      end else begin
        exp_lat = n; exp_we = 1'b0; exp_waddr = '0; exp_data = '0;
        for (int i = 0; i < n; i++) begin
          sh = sdata >> (8 * i);
          exp_q.push_back({17'(addr + 32'(i)), sh[7:0]});
          ref_mem[int'((addr + 32'(i)) & A_MASK)] = sh[7:0];
        end
      end
      do_op(we, waddr, addr, sdata, {kind != 0, kind == 2, uns, size}, lat, st);
      checks++; if (lat !== exp_lat) begin failures++; $display("FAIL rand%0d_latency kind=%0d got=%0d exp=%0d", t, kind, lat, exp_lat); end
      checks++; if (wb_wdata !== exp_data || wb_we !== exp_we || wb_waddr !== exp_waddr) begin
        failures++; $display("FAIL rand%0d_wb kind=%0d got=%0h/%0h/%0d exp=%0h/%0h/%0d", t, kind, wb_wdata, wb_we, wb_waddr, exp_data, exp_we, exp_waddr);
      end
      checks++; if (wr_q.size() !== exp_q.size()) begin failures++; $display("FAIL rand%0d_write_count got=%0d exp=%0d", t, wr_q.size(), exp_q.size()); end
      while (wr_q.size() > 0 && exp_q.size() > 0) begin
        got_w = wr_q.pop_front();
        exp_w = exp_q.pop_front();
        checks++; if (got_w !== exp_w) begin failures++; $display("FAIL rand%0d_write got=%0h exp=%0h", t, got_w, exp_w); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_word();
    test_loads();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
